// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared bus types, size-mask codes and FSM states for the data-memory responder
package dmem_responder_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  typedef logic [DATA_W-1:0] data_bus_t;
  typedef logic [ADDR_W-1:0] addr_bus_t;

  // One-hot store size codes, shared with the MEM stage that produces them.
  localparam logic [3:0] MASK_D = 4'b1000;
  localparam logic [3:0] MASK_W = 4'b0100;
  localparam logic [3:0] MASK_H = 4'b0010;
  localparam logic [3:0] MASK_B = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Decoded store size: byte strobe for an aligned access and the low
  // address bits that must be zero for that size.
  typedef struct packed {
    logic       valid;
    logic [7:0] strb;
    logic [2:0] align;
  } size_dec_t;

  function automatic size_dec_t decode_size(input logic [3:0] mask);
    size_dec_t d;
    d.valid = 1'b1;
    d.strb  = 8'h00;
    d.align = 3'b000;
    case (mask)
      MASK_D: begin d.strb = 8'hFF; d.align = 3'b111; end
      MASK_W: begin d.strb = 8'h0F; d.align = 3'b011; end
      MASK_H: begin d.strb = 8'h03; d.align = 3'b001; end
      MASK_B: begin d.strb = 8'h01; d.align = 3'b000; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - DEPTH x 64 byte-enabled synchronous RAM with registered read
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [7:0]               strb_i,
  input  data_bus_t                wdata_i,
  output data_bus_t                rdata_o
);

  data_bus_t mem_q [DEPTH];
  data_bus_t rdata_q;

  // Byte-enabled write or one-cycle registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (strb_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with fixed latency and aligned return data
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ReqValid,
  output logic      ReqReady,
  input  logic      ReqWrite,
  input  addr_bus_t Raddr,
  input  addr_bus_t Waddr,
  input  data_bus_t WData,
  input  logic [3:0] Wmask,
  output logic      RespValid,
  output data_bus_t RespData,
  output logic      RespErr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  addr_bus_t        addr_q;
  data_bus_t        wdata_q;
  logic [3:0]       mask_q;
  logic             resp_err_q;
  logic             resp_load_q;

  logic             accept;
  logic             enter_resp;

  // With LATENCY=1 the commit edge is the accept edge, so checks must see the
  // live request while idle and the latched copy afterwards.
  logic             src_write;
  addr_bus_t        src_addr;
  data_bus_t        src_wdata;
  logic [3:0]       src_mask;

  addr_bus_t        off;
  size_dec_t        dec;
  logic             range_err;
  logic             size_err;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [7:0]       strb;
  data_bus_t        wdata_sh;
  logic             sram_en;
  data_bus_t        rd_data;

  assign accept = ReqValid && (state_q == S_IDLE);

  assign src_write = (state_q == S_IDLE) ? ReqWrite : write_q;
  assign src_addr  = (state_q == S_IDLE) ? (ReqWrite ? Waddr : Raddr) : addr_q;
  assign src_wdata = (state_q == S_IDLE) ? WData : wdata_q;
  assign src_mask  = (state_q == S_IDLE) ? Wmask : mask_q;

  assign off       = src_addr - BASE_ADDR;
  assign range_err = (off >= SPAN);
  assign dec       = decode_size(src_mask);
  assign size_err  = src_write && (!dec.valid || ((src_addr[2:0] & dec.align) != 3'b000));
  assign req_err   = range_err || size_err;
  assign idx       = off[3+IDX_W-1:3];
  assign strb      = dec.strb << src_addr[2:0];
  assign wdata_sh  = src_wdata << {src_addr[2:0], 3'b000};

  // Loads read and stores commit on the same edge, so accesses stay in request order.
  assign sram_en = enter_resp && !req_err && rst_n;

  dmem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (src_write),
    .idx_i   (idx),
    .strb_i  (strb),
    .wdata_i (wdata_sh),
    .rdata_o (rd_data)
  );

  // Next-state logic: IDLE -> (WAIT for LATENCY-1 cycles) -> RESP for one cycle -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, countdown and response flags; a reset drops any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      resp_err_q  <= 1'b0;
      resp_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_err_q  <= enter_resp ? req_err : 1'b0;
      resp_load_q <= enter_resp ? (!src_write && !req_err) : 1'b0;
    end
  end

  // Capture the request on accept; later input changes do not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      write_q <= ReqWrite;
      addr_q  <= ReqWrite ? Waddr : Raddr;
      wdata_q <= WData;
      mask_q  <= Wmask;
    end
  end

  assign ReqReady  = (state_q == S_IDLE);
  assign RespValid = (state_q == S_RESP);
  assign RespErr   = resp_err_q;
  assign RespData  = resp_load_q ? (rd_data >> {addr_q[2:0], 3'b000}) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [63:0] Raddr    = '0;
  logic [63:0] Waddr    = '0;
  logic [63:0] WData    = '0;
  logic [3:0]  Wmask    = '0;
  logic        ReqReady;
  logic        RespValid;
  logic [63:0] RespData;
  logic        RespErr;

  always #5 clk = ~clk;

  dmem_responder #(
    .BASE_ADDR (64'h8000_0000),
    .DEPTH     (4096),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .Raddr     (Raddr),
    .Waddr     (Waddr),
    .WData     (WData),
    .Wmask     (Wmask),
    .RespValid (RespValid),
    .RespData  (RespData),
    .RespErr   (RespErr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_data_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];
  int          pushed = 0;

  logic chk_idle = 1'b0;
  logic b2b      = 1'b0;
  logic done     = 1'b0;

  int tests = 0;
  int fails = 0;

  // Monitor and scoreboard
  initial begin
    logic        prev_ready;
    int          last_acc;
    logic        last_acc_b2b;
    int          seen;
    logic [63:0] ed;
    logic        ee;
    int          ec;
    prev_ready   = 1'b1;
    last_acc     = -100;
    last_acc_b2b = 1'b0;
    seen         = 0;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        tests += 4;
        if (ReqReady !== 1'b1) begin fails++; $display("FAIL idle_ready got=%b exp=1", ReqReady); end
        if (RespValid !== 1'b0) begin fails++; $display("FAIL idle_respvalid got=%b exp=0", RespValid); end
        if (RespData !== 64'h0) begin fails++; $display("FAIL idle_respdata got=%h exp=0", RespData); end
        if (RespErr !== 1'b0) begin fails++; $display("FAIL idle_resperr got=%b exp=0", RespErr); end
      end
      if (RespValid === 1'b1) begin
        seen++;
        tests++;
        if (ReqReady !== 1'b0) begin fails++; $display("FAIL ready_in_resp got=%b exp=0", ReqReady); end
        if (exp_data_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp got RespValid=1 at cyc %0d exp none", cyc);
        end else begin
          ed = exp_data_q.pop_front();
          ee = exp_err_q.pop_front();
          ec = exp_cyc_q.pop_front();
          tests += 3;
          if (RespData !== ed) begin fails++; $display("FAIL resp_data got=%h exp=%h", RespData, ed); end
          if (RespErr !== ee) begin fails++; $display("FAIL resp_err got=%b exp=%b", RespErr, ee); end
          if (cyc != ec) begin fails++; $display("FAIL resp_latency got cyc=%0d exp cyc=%0d", cyc, ec); end
        end
      end
      if (prev_ready && ReqReady === 1'b0) begin
        if (b2b && last_acc_b2b) begin
          tests++;
          if (cyc - last_acc != LAT + 1) begin
            fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_acc, LAT + 1);
          end
        end
        last_acc     = cyc;
        last_acc_b2b = b2b;
      end
      prev_ready = (ReqReady === 1'b1);
      if (done) begin
        tests += 2;
        if (exp_data_q.size() != 0) begin
          fails++; $display("FAIL pending_resp got=%0d exp=0", exp_data_q.size());
        end
        if (seen != pushed) begin
          fails++; $display("FAIL resp_count got=%0d exp=%0d", seen, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  // Issue one request at a negedge where the responder is idle; returns at the negedge after accept.
  task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [3:0] m, input logic e_err, input logic [63:0] e_data,
                       input logic hold, input logic expect_resp);
    int guard;
    guard = 0;
    while (ReqReady !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        $display("FAIL issue_timeout got ReqReady=%b exp=1", ReqReady);
        $fatal(1, "responder never became ready");
      end
    end
    ReqValid = 1'b1;
    ReqWrite = wr;
    if (wr) begin
      Waddr = addr;
      Raddr = ~addr;
      WData = wd;
      Wmask = m;
    end else begin
      Raddr = addr;
      Waddr = ~addr;
      WData = {$urandom, $urandom};
      Wmask = 4'b0110;
    end
    if (expect_resp) begin
      exp_data_q.push_back(e_data);
      exp_err_q.push_back(e_err);
      exp_cyc_q.push_back(cyc + LAT);
      pushed++;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      ReqValid = 1'b0;
      Raddr    = {32'h0, $urandom};
      Waddr    = {32'h0, $urandom};
      WData    = {$urandom, $urandom};
      Wmask    = 4'($urandom);
      ReqWrite = 1'($urandom);
    end
  endtask

  // Directed stimulus
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_idle = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle = 1'b0;

    issue(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 4'b1000, 1'b0, 64'h0, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_0008, 64'h0, 4'b0000, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
    issue(1'b1, 64'h8000_000B, 64'h0000_0000_0000_00AB, 4'b0001, 1'b0, 64'h0, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_0008, 64'h0, 4'b0000, 1'b0, 64'h1122_3344_AB66_7788, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_000B, 64'h0, 4'b0000, 1'b0, 64'h0000_0011_2233_44AB, 1'b0, 1'b1);
    issue(1'b1, 64'h8000_0006, 64'h0000_0000_9999_9999, 4'b0100, 1'b1, 64'h0, 1'b0, 1'b1);
    issue(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1, 64'h0, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_0008, 64'h0, 4'b0000, 1'b0, 64'h1122_3344_AB66_7788, 1'b0, 1'b1);
    issue(1'b0, 64'h7FFF_FFF8, 64'h0, 4'b0000, 1'b1, 64'h0, 1'b0, 1'b1);
    issue(1'b1, 64'h8000_7FFE, 64'h0000_0000_0000_BEEF, 4'b0010, 1'b0, 64'h0, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_7FFE, 64'h0, 4'b0000, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0, 1'b1);
    issue(1'b0, 64'h8000_8000, 64'h0, 4'b0000, 1'b1, 64'h0, 1'b0, 1'b1);
    issue(1'b1, 64'h8000_0010, 64'h0102_0304_0506_0708, 4'b1000, 1'b0, 64'h0, 1'b0, 1'b1);

    b2b = 1'b1;
    issue(1'b1, 64'h8000_0020, 64'h5555_5555_DEAD_BEEF, 4'b0100, 1'b0, 64'h0, 1'b1, 1'b1);
    issue(1'b1, 64'h8000_0024, 64'hAAAA_AAAA_0BAD_F00D, 4'b0100, 1'b0, 64'h0, 1'b1, 1'b1);
    issue(1'b0, 64'h8000_0020, 64'h0, 4'b0000, 1'b0, 64'h0BAD_F00D_DEAD_BEEF, 1'b1, 1'b1);
    issue(1'b0, 64'h8000_0022, 64'h0, 4'b0000, 1'b0, 64'h0000_0BAD_F00D_DEAD, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    b2b = 1'b0;

    issue(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle = 1'b0;
    issue(1'b0, 64'h8000_0010, 64'h0, 4'b0000, 1'b0, 64'h0102_0304_0506_0708, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    done = 1'b1;
  end

endmodule
